// File: rtl/posit_add_arbiter_pkg.sv
// Shared types for the posit32/es2 adder arbiter: posit value types, request/response structs,
// and the posit field decoder used by the adder datapath.
package posit_add_arbiter_pkg;

  localparam int NBITS   = 32;
  localparam int ES      = 2;
  localparam int IDW_MAX = 4;

  typedef logic [NBITS-1:0] posit_t;

  localparam posit_t POSIT_NAR    = 32'h8000_0000;
  localparam posit_t POSIT_MAXPOS = 32'h7FFF_FFFF;
  localparam posit_t POSIT_MINPOS = 32'h0000_0001;

  typedef struct packed {
    posit_t               in1;
    posit_t               in2;
    logic [IDW_MAX-1:0]   id;
  } arb_req_t;

  typedef struct packed {
    posit_t               result;
    logic                 inf;
    logic                 zero;
    logic [IDW_MAX-1:0]   id;
  } arb_rsp_t;

  // scale = 4*k + exponent; mant carries the hidden one at bit 29
  typedef struct packed {
    logic                 sign;
    logic signed [9:0]    scale;
    logic [29:0]          mant;
  } posit_unpk_t;

  function automatic posit_unpk_t posit_decode(input posit_t p);
    posit_unpk_t u;
    logic [30:0] a;
    logic [30:0] rem;
    logic        run;
    int          m;
    int          k;
    a   = 31'(p[31] ? (~p + 32'd1) : p);
    m   = 1;
    run = 1'b1;
    for (int i = 29; i >= 0; i--) begin
      if (run && (a[i] == a[30])) m++;
      else run = 1'b0;
    end
    rem     = a << (m + 1);
    k       = a[30] ? (m - 1) : -m;
    u.sign  = p[31];
    u.scale = 10'(k * 4 + int'(rem[30:29]));
    u.mant  = {1'b1, rem[28:0]};
    return u;
  endfunction

endpackage

// File: rtl/posit_add_arbiter_rr_arbiter.sv
// Round-robin grant: first requester after ptr (mod NREQ) with req set, only while en is high.
// Pure combinational; grant is one-hot or zero.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/positadd.sv
// Combinational posit32/es2 adder with round-to-nearest-even on the encoding.
// NaR on either input yields NaR with inf set; results never round to zero or NaR.
module positadd
  import posit_add_arbiter_pkg::*;
(
  input  logic [NBITS-1:0] in1,
  input  logic [NBITS-1:0] in2,
  input  logic             start,
  output logic [NBITS-1:0] result,
  output logic             inf,
  output logic             zero,
  output logic             done
);

  posit_unpk_t ua, ub, big, sml;
  logic        swap;
  int          diff, lead, sc, k, sh;
  logic [32:0] mbig, msml, al, lost, norm;
  logic [33:0] sum;
  logic [63:0] x, y;
  logic [31:0] rnd;
  logic [30:0] mag;
  posit_t      res;

  always_comb begin
    ua   = posit_decode(in1);
    ub   = posit_decode(in2);
    swap = ($signed(ub.scale) > $signed(ua.scale)) ||
           ((ub.scale == ua.scale) && (ub.mant > ua.mant));
    big  = swap ? ub : ua;
    sml  = swap ? ua : ub;
    diff = int'($signed(big.scale)) - int'($signed(sml.scale));
    mbig = {big.mant, 3'b000};
    msml = {sml.mant, 3'b000};
    // three guard bits plus a sticky bit folded into the aligned operand's lsb
    if (diff >= 33) begin
      al   = 33'd1;
      lost = '0;
    end else begin
      al   = msml >> diff;
      lost = msml << (33 - diff);
    end
    al[0] = al[0] | (|lost);
    sum   = (big.sign == sml.sign) ? ({1'b0, mbig} + {1'b0, al})
                                   : ({1'b0, mbig} - {1'b0, al});
    lead = 0;
    for (int i = 0; i < 34; i++) begin
      if (sum[i]) lead = i;
    end
    norm = 33'(sum << (33 - lead));
    sc   = int'($signed(big.scale)) + lead - 32;
    k    = sc >>> 2;
    // arithmetic shift of a 10/01 seed expands it into the regime run
    x    = {(k >= 0) ? 2'b10 : 2'b01, sc[1:0], norm, 27'd0};
    sh   = (k >= 0) ? k : (-k - 1);
    if (sh > 63) sh = 63;
    y    = $signed(x) >>> sh;
    rnd  = {1'b0, y[63:33]} + {31'd0, y[32] & (y[33] | (|y[31:0]))};
    if ((k >= 30) || rnd[31]) mag = POSIT_MAXPOS[30:0];
    else if ((k < -30) || (rnd == 32'd0)) mag = POSIT_MINPOS[30:0];
    else mag = rnd[30:0];
    res  = big.sign ? (~{1'b0, mag} + 32'd1) : {1'b0, mag};

    inf = 1'b0;
    if ((in1 == POSIT_NAR) || (in2 == POSIT_NAR)) begin
      result = POSIT_NAR;
      inf    = 1'b1;
    end else if (in1 == '0) begin
      result = in2;
    end else if (in2 == '0) begin
      result = in1;
    end else if (sum == '0) begin
      result = '0;
    end else begin
      result = res;
    end
    zero = (result == '0);
    done = start;
  end

endmodule

// File: rtl/posit_add_arbiter.sv
// Round-robin share of one posit32/es2 adder among NREQ requesters; 2-stage pipeline, 1 op/cycle,
// out_ready low stalls s2 then s1 and drops req_ready. POSIT_ADD_ARB_STATS_EN adds stat_ops/stat_stall.
module posit_add_arbiter
  import posit_add_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_in1,
  input  logic [NREQ*32-1:0]   req_in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_inf,
  output logic                 out_zero,
  output logic [IDW-1:0]       out_id
`ifdef POSIT_ADD_ARB_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
`endif
);

  logic            s1_valid, s2_valid;
  arb_req_t        s1_req, req_sel;
  arb_rsp_t        s2_rsp, add_rsp;
  logic            adv1, adv2, hs;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx, last_grant;
  posit_t          add_result;
  logic            add_inf, add_zero, add_done_unused;

  assign adv2 = !s2_valid || out_ready;
  assign adv1 = !s1_valid || adv2;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .en    (adv1),
    .ptr   (last_grant),
    .grant (grant),
    .idx   (grant_idx)
  );

  // grant only ever selects a valid requester, so any grant is a handshake
  assign req_ready = grant;
  assign hs        = |grant;

  always_comb begin
    req_sel     = '0;
    req_sel.in1 = req_in1[32*grant_idx +: 32];
    req_sel.in2 = req_in2[32*grant_idx +: 32];
    req_sel.id  = IDW_MAX'(grant_idx);
  end

  positadd u_add (
    .in1    (s1_req.in1),
    .in2    (s1_req.in2),
    .start  (s1_valid),
    .result (add_result),
    .inf    (add_inf),
    .zero   (add_zero),
    .done   (add_done_unused)
  );

  always_comb begin
    add_rsp.result = add_result;
    add_rsp.inf    = add_inf;
    add_rsp.zero   = add_zero;
    add_rsp.id     = s1_req.id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_req     <= '0;
      s2_rsp     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_rsp <= add_rsp;
      end
      if (adv1) begin
        s1_valid <= hs;
        if (hs) s1_req <= req_sel;
      end
      if (hs) last_grant <= grant_idx;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_rsp.result;
  assign out_inf    = s2_rsp.inf;
  assign out_zero   = s2_rsp.zero;
  assign out_id     = s2_rsp.id[IDW-1:0];

  generate
    if (IDW < IDW_MAX) begin : g_id_pad
      logic id_hi_unused;
      assign id_hi_unused = |s2_rsp.id[IDW_MAX-1:IDW];
    end
  endgenerate

`ifdef POSIT_ADD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (s2_valid && out_ready && (stat_ops != 32'hFFFF_FFFF))
        stat_ops <= stat_ops + 32'd1;
      if (s2_valid && !out_ready && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed bench for posit_add_arbiter: adder vectors, round-robin order, backpressure, async reset.
// Stats counters are exercised only when POSIT_ADD_ARB_STATS_EN is defined.
module tb_posit_add_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_in1, req_in2;
  logic         out_valid, out_ready;
  logic [31:0]  out_result;
  logic         out_inf, out_zero;
  logic [1:0]   out_id;
`ifdef POSIT_ADD_ARB_STATS_EN
  logic [31:0]  stat_ops, stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] op_val [4];

  posit_add_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_inf    (out_inf),
    .out_zero   (out_zero),
    .out_id     (out_id)
`ifdef POSIT_ADD_ARB_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_in1[32*i +: 32] = a;
    req_in2[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_inf, input logic exp_zero);
    @(negedge clk);
    set_op(idx, a, b);
    req_valid = 4'(1 << idx);
    #1 check({tag, ".rdy"}, 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    req_valid = '0;
    check({tag, ".early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".vld"},  32'(out_valid), 32'd1);
    check({tag, ".res"},  out_result, exp_r);
    check({tag, ".inf"},  32'(out_inf), 32'(exp_inf));
    check({tag, ".zero"}, 32'(out_zero), 32'(exp_zero));
    check({tag, ".id"},   32'(out_id), 32'(idx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    req_in1 = '0;
    req_in2 = '0;
    for (int i = 0; i < 4; i++) op_val[i] = 32'h4000_0000 | (32'(i) << 16);

    do_reset();
    #1;
    check("rst.vld",  32'(out_valid), 32'd0);
    check("rst.res",  out_result, 32'd0);
    check("rst.inf",  32'(out_inf), 32'd0);
    check("rst.zero", 32'(out_zero), 32'd0);
    check("rst.id",   32'(out_id), 32'd0);
    check("rst.rdy",  32'(req_ready), 32'd0);

    do_op("one_plus_one", 0, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 1'b0, 1'b0);
    do_op("nar",          2, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0);
    do_op("zero_zero",    2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    do_op("one_half",     1, 32'h4000_0000, 32'h3800_0000, 32'h4400_0000, 1'b0, 1'b0);
    do_op("two_mhalf",    3, 32'h4800_0000, 32'hC800_0000, 32'h4400_0000, 1'b0, 1'b0);
    do_op("cancel",       1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 1'b0, 1'b1);
    do_op("mone_mone",    0, 32'hC000_0000, 32'hC000_0000, 32'hB800_0000, 1'b0, 1'b0);
    do_op("maxpos",       3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    do_op("minpos",       0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);

    // all requesters active, consumer always ready: strict rotation, no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, op_val[i], 32'h0);
    req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1 check($sformatf("rr.rdy%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check($sformatf("rr.vld%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("rr.id%0d", c),  32'(out_id), 32'((c - 2) % 4));
        check($sformatf("rr.res%0d", c), out_result, op_val[(c - 2) % 4]);
      end
      @(negedge clk);
    end
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      #1 check($sformatf("rr.drain_id%0d", c), 32'(out_id), 32'(c));
      check($sformatf("rr.drain_vld%0d", c), 32'(out_valid), 32'd1);
      @(negedge clk);
    end

    // consumer stalls for 5 cycles: two ops fill the pipe, then everything holds
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b0;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if ((req_valid & req_ready) != 4'h0) hs++;
      if (c >= 2) begin
        check($sformatf("bp.rdy%0d", c), 32'(req_ready), 32'd0);
        check($sformatf("bp.vld%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("bp.id%0d", c),  32'(out_id), 32'd0);
        check($sformatf("bp.res%0d", c), out_result, op_val[0]);
      end
      @(negedge clk);
    end
    check("bp.handshakes", 32'(hs), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("bp.rel_id%0d", c), 32'(out_id), 32'(c));
      check($sformatf("bp.rel_res%0d", c), out_result, op_val[c]);
      check($sformatf("bp.rel_rdy%0d", c), 32'(req_ready), 32'(1 << ((c + 2) % 4)));
      @(negedge clk);
    end

    // two ops in flight when reset hits
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("arst.vld", 32'(out_valid), 32'd0);
    check("arst.res", out_result, 32'd0);
    req_valid = 4'b1010;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst.rdy_first", 32'(req_ready), 32'b0010);
    @(negedge clk);
    #1 check("arst.rdy_second", 32'(req_ready), 32'b1000);
    check("arst.vld_s1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("arst.out_vld", 32'(out_valid), 32'd1);
    check("arst.out_id", 32'(out_id), 32'd1);
    req_valid = '0;
    repeat (3) @(negedge clk);

`ifdef POSIT_ADD_ARB_STATS_EN
    do_reset();
    #1 check("stat.ops_rst", stat_ops, 32'd0);
    check("stat.stall_rst", stat_stall, 32'd0);
    set_op(0, 32'h4000_0000, 32'h4000_0000);
    hs = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c inside {5, 6, 7});
      req_valid = (hs < 10) ? 4'b0001 : 4'b0000;
      #1;
      if ((req_valid & req_ready) != 4'h0) hs++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("stat.ops", stat_ops, 32'd10);
    check("stat.stall", stat_stall, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
